// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch/decode pipeline boundary.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_ILEN   = 32;
  localparam int DEF_SIDE_W = 1;

  typedef struct packed {
    logic [DEF_ILEN-1:0]   instr;
    logic [DEF_XLEN-1:0]   pc;
    logic [DEF_XLEN-1:0]   pc_four;
    logic [DEF_SIDE_W-1:0] side;
  } if_id_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  function automatic int if_id_w(input int xlen, input int ilen, input int side_w);
    return ilen + 2 * xlen + side_w;
  endfunction

endpackage

// File: rtl/pipe_skid_core.sv
// Generic 2-entry valid/ready skid buffer; ready towards upstream comes from a flop.
//
// state | meaning
// EMPTY | main invalid, skid invalid
// ONE   | main valid, skid invalid
// FULL  | main and skid valid, upstream stalled
module pipe_skid_core
  import pipe_pkg::*;
#(
  parameter int          W      = 8,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         valid_up,
  output logic         ready_up,
  input  logic [W-1:0] data_up,
  output logic         valid_dn,
  input  logic         ready_dn,
  output logic [W-1:0] data_dn,
  output logic [1:0]   occ
);

  occ_e         state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         ready_q;
  logic         accept;
  logic         fire;
  logic         main_vld;
  logic         skid_vld;

  assign main_vld = (state == ONE) || (state == FULL);
  assign skid_vld = (state == FULL);
  assign accept   = valid_up & ready_q;
  assign fire     = main_vld & ready_dn;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state   <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= data_up;
            state  <= ONE;
          end
          ready_q <= 1'b1;
        end
        ONE: begin
          if (fire && accept) begin
            main_q  <= data_up;
            ready_q <= 1'b1;
          end else if (fire) begin
            main_q  <= BUBBLE;
            state   <= EMPTY;
            ready_q <= 1'b1;
          end else if (accept) begin
            skid_q  <= data_up;
            state   <= FULL;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        FULL: begin
          if (fire) begin
            main_q  <= skid_q;
            skid_q  <= BUBBLE;
            state   <= ONE;
            ready_q <= 1'b1;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= EMPTY;
          main_q  <= BUBBLE;
          skid_q  <= BUBBLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_up = ready_q;
  assign valid_dn = main_vld;
  assign data_dn  = main_q;
  assign occ      = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!skid_vld || main_vld);
      assert (ready_q == (state != FULL));
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with skid entry; packs fetch fields into one payload.
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter int              SIDE_W    = 1,
  parameter logic [ILEN-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR[ILEN-1:0]
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_valid_up,
  output logic              o_ready_up,
  input  logic [ILEN-1:0]   i_instr,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_pc_four,
  input  logic [SIDE_W-1:0] i_side,
  output logic              o_valid_dn,
  input  logic              i_ready_dn,
  output logic [ILEN-1:0]   o_instr,
  output logic [XLEN-1:0]   o_pc,
  output logic [XLEN-1:0]   o_pc_four,
  output logic [SIDE_W-1:0] o_side,
  output logic [1:0]        o_occ
);

  localparam int W = if_id_w(XLEN, ILEN, SIDE_W);
  localparam logic [W-1:0] BUBBLE = {NOP_INSTR, {(2 * XLEN + SIDE_W){1'b0}}};

  logic [W-1:0] data_up;
  logic [W-1:0] data_dn;

  assign data_up = {i_instr, i_pc, i_pc_four, i_side};
  assign {o_instr, o_pc, o_pc_four, o_side} = data_dn;

  pipe_skid_core #(
    .W      (W),
    .BUBBLE (BUBBLE)
  ) u_core (
    .clk      (i_clk),
    .reset    (i_reset),
    .flush    (i_flush),
    .valid_up (i_valid_up),
    .ready_up (o_ready_up),
    .data_up  (data_up),
    .valid_dn (o_valid_dn),
    .ready_dn (i_ready_dn),
    .data_dn  (data_dn),
    .occ      (o_occ)
  );

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed and scoreboarded checks of the IF/ID skid register.
module tb_if_id_skid_reg;

  logic        clk = 1'b0;
  logic        reset, flush, valid_up, ready_dn;
  logic [31:0] instr, pc, pc_four;
  logic [0:0]  side;
  logic        ready_up, valid_dn;
  logic [31:0] o_instr, o_pc, o_pc_four;
  logic [0:0]  o_side;
  logic [1:0]  occ;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  if_id_skid_reg dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_flush    (flush),
    .i_valid_up (valid_up),
    .o_ready_up (ready_up),
    .i_instr    (instr),
    .i_pc       (pc),
    .i_pc_four  (pc_four),
    .i_side     (side),
    .o_valid_dn (valid_dn),
    .i_ready_dn (ready_dn),
    .o_instr    (o_instr),
    .o_pc       (o_pc),
    .o_pc_four  (o_pc_four),
    .o_side     (o_side),
    .o_occ      (occ)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p);
    valid_up = v;
    pc       = p;
    pc_four  = p + 32'd4;
    instr    = 32'hA500_0000 | p;
    side     = p[2];
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; ready_dn = 1'b0;
    drive(1'b1, 32'h100);
    tick();
    tick();
    vecs++;
    if (valid_dn !== 1'b0 || o_instr !== 32'h13 || o_pc !== 32'h0 || o_pc_four !== 32'h0 ||
        o_side !== 1'b0 || ready_up !== 1'b1 || occ !== 2'd0) begin
      errs++;
      $display("FAIL reset_state: valid=%b instr=%h pc=%h pc4=%h side=%b ready=%b occ=%0d want 0/00000013/0/0/0/1/0",
               valid_dn, o_instr, o_pc, o_pc_four, o_side, ready_up, occ);
    end
    reset = 1'b0;
    tick();
    vecs++;
    if (valid_dn !== 1'b1 || o_pc !== 32'h100 || o_instr !== 32'hA500_0100 || o_pc_four !== 32'h104) begin
      errs++;
      $display("FAIL first_accept: valid=%b pc=%h instr=%h pc4=%h want 1/100/a5000100/104",
               valid_dn, o_pc, o_instr, o_pc_four);
    end
    drive(1'b0, 32'h0);
    ready_dn = 1'b1;
    tick();
    vecs++;
    if (valid_dn !== 1'b0 || o_instr !== 32'h13 || occ !== 2'd0) begin
      errs++;
      $display("FAIL reset_drain: valid=%b instr=%h occ=%0d want 0/00000013/0", valid_dn, o_instr, occ);
    end
  endtask

  task automatic test_stream();
    ready_dn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(4 * k));
      tick();
      vecs++;
      if (valid_dn !== 1'b1 || o_pc !== 32'(4 * k) || o_side !== 1'(k & 1) || occ !== 2'd1 || ready_up !== 1'b1) begin
        errs++;
        $display("FAIL stream_%0d: valid=%b pc=%h side=%b occ=%0d ready=%b want 1/%h/%0d/1/1",
                 k, valid_dn, o_pc, o_side, occ, ready_up, 4 * k, k & 1);
      end
    end
    drive(1'b0, 32'h0);
    tick();
    vecs++;
    if (valid_dn !== 1'b0 || o_instr !== 32'h13 || o_pc !== 32'h0) begin
      errs++;
      $display("FAIL stream_end: valid=%b instr=%h pc=%h want 0/00000013/0", valid_dn, o_instr, o_pc);
    end
  endtask

  task automatic fill_full(input logic [31:0] p0, input logic [31:0] p1);
    ready_dn = 1'b0;
    drive(1'b1, p0);
    tick();
    drive(1'b1, p1);
    tick();
    drive(1'b0, 32'h0);
  endtask

  task automatic test_backpressure();
    fill_full(32'h10, 32'h14);
    vecs++;
    if (occ !== 2'd2 || ready_up !== 1'b0 || o_pc !== 32'h10 || valid_dn !== 1'b1) begin
      errs++;
      $display("FAIL bp_full: occ=%0d ready=%b pc=%h valid=%b want 2/0/10/1", occ, ready_up, o_pc, valid_dn);
    end
    tick();
    vecs++;
    if (occ !== 2'd2 || o_pc !== 32'h10) begin
      errs++;
      $display("FAIL bp_hold: occ=%0d pc=%h want 2/10", occ, o_pc);
    end
    ready_dn = 1'b1;
    tick();
    vecs++;
    if (o_pc !== 32'h14 || o_pc_four !== 32'h18 || occ !== 2'd1 || ready_up !== 1'b1) begin
      errs++;
      $display("FAIL bp_promote: pc=%h pc4=%h occ=%0d ready=%b want 14/18/1/1", o_pc, o_pc_four, occ, ready_up);
    end
    tick();
    vecs++;
    if (valid_dn !== 1'b0 || o_instr !== 32'h13 || occ !== 2'd0) begin
      errs++;
      $display("FAIL bp_drain: valid=%b instr=%h occ=%0d want 0/00000013/0", valid_dn, o_instr, occ);
    end
  endtask

  task automatic test_flush();
    fill_full(32'h18, 32'h1C);
    flush = 1'b1;
    drive(1'b1, 32'h20);
    tick();
    flush = 1'b0;
    vecs++;
    if (valid_dn !== 1'b0 || o_instr !== 32'h13 || o_pc !== 32'h0 || ready_up !== 1'b1 || occ !== 2'd0) begin
      errs++;
      $display("FAIL flush_full: valid=%b instr=%h pc=%h ready=%b occ=%0d want 0/00000013/0/1/0",
               valid_dn, o_instr, o_pc, ready_up, occ);
    end
    drive(1'b0, 32'h0);
    ready_dn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++;
      if (valid_dn !== 1'b0) begin
        errs++;
        $display("FAIL flush_quiet_%0d: valid=%b pc=%h want 0", k, valid_dn, o_pc);
      end
    end
    // flush in ONE with simultaneous fire and accept: both are lost from the stage
    drive(1'b1, 32'h24);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h28);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    vecs++;
    if (valid_dn !== 1'b0 || occ !== 2'd0 || o_pc !== 32'h0) begin
      errs++;
      $display("FAIL flush_one: valid=%b occ=%0d pc=%h want 0/0/0", valid_dn, occ, o_pc);
    end
  endtask

  task automatic test_reset_in_full();
    fill_full(32'h30, 32'h34);
    reset = 1'b1; flush = 1'b1; ready_dn = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0;
    vecs++;
    if (occ !== 2'd0 || valid_dn !== 1'b0 || ready_up !== 1'b1 || o_instr !== 32'h13) begin
      errs++;
      $display("FAIL reset_full: occ=%0d valid=%b ready=%b instr=%h want 0/0/1/00000013",
               occ, valid_dn, ready_up, o_instr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++;
      if (valid_dn !== 1'b0) begin
        errs++;
        $display("FAIL reset_quiet_%0d: valid=%b want 0", k, valid_dn);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] seq;
    logic [31:0] exp_pc;
    logic        r_a, r_b, acc, fir;
    int          bad;
    seq = 32'h1000;
    q.delete();
    bad = 0;
    void'($urandom(32'h5EED_0001));
    for (int c = 0; c < 10000; c++) begin
      flush    = ($urandom_range(0, 199) == 0);
      ready_dn = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
      drive(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, seq);
      vecs++;
      if (occ !== 2'(q.size()) || ready_up !== (q.size() < 2) || valid_dn !== (q.size() > 0)) begin
        errs++; bad++;
        if (bad < 10)
          $display("FAIL rand_occ c=%0d: occ=%0d ready=%b valid=%b want %0d", c, occ, ready_up, valid_dn, q.size());
      end
      r_a = ready_up;
      ready_dn = ~ready_dn;
      #1;
      r_b = ready_up;
      ready_dn = ~ready_dn;
      #1;
      vecs++;
      if (r_a !== r_b || ready_up !== r_a) begin
        errs++; bad++;
        if (bad < 10) $display("FAIL rand_ready_comb c=%0d: ready moved %b->%b with ready_dn", c, r_a, r_b);
      end
      acc = valid_up & (q.size() < 2);
      fir = (q.size() > 0) & ready_dn;
      if (fir) begin
        exp_pc = q.pop_front();
        vecs++;
        if (o_pc !== exp_pc || o_instr !== (32'hA500_0000 | exp_pc) || o_pc_four !== exp_pc + 32'd4 ||
            o_side !== exp_pc[2]) begin
          errs++; bad++;
          if (bad < 10) $display("FAIL rand_data c=%0d: pc=%h instr=%h want pc=%h", c, o_pc, o_instr, exp_pc);
        end
      end else if (q.size() == 0) begin
        vecs++;
        if (o_instr !== 32'h13 || o_pc !== 32'h0) begin
          errs++; bad++;
          if (bad < 10) $display("FAIL rand_bubble c=%0d: instr=%h pc=%h want 00000013/0", c, o_instr, o_pc);
        end
      end
      if (flush) q.delete();
      else if (acc) begin
        q.push_back(seq);
        seq = seq + 32'd4;
      end
      tick();
    end
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ready_dn = 1'b0;
    drive(1'b0, 32'h0);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_in_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
